temp_sampler: RTL and testbench
===============================

# temp_sampler

Front-end stage of the greenhouse controller. It drives a serial 8-bit temperature ADC over a 3-wire interface and alternately converts the inside (channel 0) and outside (channel 1) sensors. Each channel is smoothed with a power-of-two moving average. The stage feeds the thermostat FSM with `greenhouse_temp` and the outside-warmer flag `temp_g_greenhouse_temp`.

## Interface
- `CLK_DIV`, default 4: `adc_sclk` half-period in `clk` cycles (≥2).
- `AVG_LOG2`, default 2: averaging window = 2^AVG_LOG2 samples per channel.
- `SAMPLE_GAP`, default 1000: idle `clk` cycles between conversion pairs (≥1).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `adc_sdo` in 1: ADC serial data, MSB first.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_sclk` out 1: ADC serial clock, idle low.
- `adc_ch` out 1: channel select; 0 = inside, 1 = outside.
- `greenhouse_temp` out 8: averaged inside temperature.
- `outside_temp` out 8: averaged outside temperature.
- `temp_g_greenhouse_temp` out 1: 1 when `outside_temp > greenhouse_temp` (strict).
- `sample_valid` out 1: one-cycle pulse when the three result outputs update.

## Operation
- States:
  - GAP: `cs_n`=1, counting.
  - SETUP: `cs_n`=0, `sclk`=0.
  - SHIFT: 16 half-periods.
  - DONE: `cs_n`=1, capture.
- Transition order: SETUP(ch0) → SHIFT → DONE → SETUP(ch1) → SHIFT → DONE → GAP → SETUP(ch0)…
- `adc_ch` changes only in DONE/GAP. It is stable throughout every SETUP+SHIFT.
- SETUP lasts CLK_DIV cycles.
- SHIFT:
  - `sclk` goes high at SHIFT entry and toggles every CLK_DIV cycles: 8 high and 8 low half-periods.
  - `adc_sdo` is sampled on the `clk` edge that ends each high half-period, i.e. the edge driving `sclk` low.
  - Bits shift in MSB first.
- DONE lasts 1 cycle. The 8-bit result is handed to that channel's averager.
- GAP lasts SAMPLE_GAP cycles.
- Averager, one per channel:
  - Holds a ring buffer of 2^AVG_LOG2 bytes and a running sum of 8+AVG_LOG2 bits.
  - Update: sum ← sum + new − oldest; the oldest entry is overwritten; the ring pointer wraps modulo 2^AVG_LOG2.
  - Output is sum >> AVG_LOG2 (floor). The sum never overflows: all-0xFF gives 255·2^AVG_LOG2.
  - Priming: the first sample after reset fills every entry with that sample and sets sum = sample << AVG_LOG2.
- Result outputs (`greenhouse_temp`, `outside_temp`, flag) update together, once per pair, in the cycle after the channel-1 DONE. `sample_valid` pulses in that same cycle.
- The flag is computed from the new averaged values, not raw samples.

## Timing
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=0, `adc_ch`=0.
  - `greenhouse_temp`=0, `outside_temp`=0, flag=0, `sample_valid`=0.
  - Averagers unprimed.
- First conversion: SETUP(ch0) begins on the first rising edge with `rst`=0, so `cs_n` falls at that edge. No initial gap.
- Per-channel `cs_n` low time: 17·CLK_DIV cycles (68 at default).
- `cs_n` high time:
  - 1 cycle between ch0 and ch1.
  - SAMPLE_GAP+1 cycles between pairs.
- Pair period: 2·(17·CLK_DIV+1)+SAMPLE_GAP cycles (1138 at defaults).
- Latency: outputs and `sample_valid` are valid 1 cycle after the ch1 DONE cycle.
- Reset mid-operation (any state):
  - Next edge: `cs_n`=1, `sclk`=0; all outputs return to reset values.
  - The partial sample is discarded and the averagers are unprimed.
  - The rule above applies after release.
- Between pulses, outputs hold their values.

## Structure
- Package `temp_pkg`:
  - Sampler state encoding (GAP, SETUP, SHIFT, DONE).
  - Channel constants CH_INSIDE=0, CH_OUTSIDE=1.
  - Default CLK_DIV/AVG_LOG2/SAMPLE_GAP.
  - Temperature width 8; shared with the thermostat block.
- Sub-module `temp_avg`, instantiated twice:
  - Parameter AVG_LOG2.
  - Ports: clk, rst, `in_valid`, `in_data[7:0]`, `avg[7:0]`.
  - Owns ring buffer, pointer, running sum and primed flag.
- The top holds the FSM, the CLK_DIV/gap counters, the bit counter, the shift register and the compare register.

## Test plan
- Reset, then the ADC model returns inside 0x32 and outside 0x14 → first `sample_valid` shows `greenhouse_temp`=50, `outside_temp`=20, flag=0 (priming, no bias).
- Primed at 50, inside steps to 60 → next four pulses give `greenhouse_temp` 52, 55, 57, 60.
- Inside and outside both 40 → flag=0. Outside then reads 44 → next pulse `outside_temp`=41, flag=1.
- Defaults, ADC drives 0xA5 then 0xFF on four consecutive pairs:
  - Each `cs_n` low window is exactly 68 cycles with 8 `sclk` rising edges.
  - `adc_ch` is stable during each window.
  - Results decode as 165, then average to 255 with no overflow.
- `rst` pulsed during SHIFT bit 3 of ch1 → next cycle `cs_n`=1, `sclk`=0, outputs 0. New `cs_n` fall on the first edge after release; the next result is primed.
- Gap check → `cs_n` high for exactly 1 cycle between channels and exactly SAMPLE_GAP+1 cycles between pairs. `sample_valid` period is 1138 cycles.

Source files
------------

// File: rtl/temp_pkg.sv
// temp_pkg: shared sampler state encoding, channel ids and greenhouse temperature defaults
package temp_pkg;
  typedef enum logic [1:0] {GAP, SETUP, SHIFT, DONE} state_t;
  localparam logic CH_INSIDE = 1'b0;
  localparam logic CH_OUTSIDE = 1'b1;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_SAMPLE_GAP = 1000;
  localparam int TEMP_W = 8;
endpackage

// File: rtl/temp_avg.sv
// temp_avg: power-of-two moving average with ring buffer, primed by the first sample
module temp_avg import temp_pkg::*; #(
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [TEMP_W-1:0] in_data,
  output logic [TEMP_W-1:0] avg
);
  localparam int N = 1 << AVG_LOG2;
  localparam int W = TEMP_W + AVG_LOG2;
  localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  logic [TEMP_W-1:0] mem [N];
  logic [PW-1:0] ptr;
  logic [W-1:0] sum, next_sum;
  logic primed;
  always_comb begin
    next_sum = primed ? sum + W'(in_data) - W'(mem[ptr]) : W'(in_data) << AVG_LOG2;
    // bypass so the owner can register the freshly updated average in the update cycle
    avg = TEMP_W'((in_valid ? next_sum : sum) >> AVG_LOG2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      primed <= 1'b0;
      sum <= '0;
      ptr <= '0;
    end else if (in_valid) begin
      sum <= next_sum;
      primed <= 1'b1;
      if (primed) begin
        mem[ptr] <= in_data;
        ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + 1'b1;
      end else begin
        for (int i = 0; i < N; i++) mem[i] <= in_data;
      end
    end
  end
endmodule

// File: rtl/temp_sampler.sv
// temp_sampler: 3-wire ADC sequencer converting inside/outside sensors with per-channel averaging
module temp_sampler import temp_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int SAMPLE_GAP = DEF_SAMPLE_GAP
) (
  input  logic clk,
  input  logic rst,
  input  logic adc_sdo,
  output logic adc_cs_n,
  output logic adc_sclk,
  output logic adc_ch,
  output logic [TEMP_W-1:0] greenhouse_temp,
  output logic [TEMP_W-1:0] outside_temp,
  output logic temp_g_greenhouse_temp,
  output logic sample_valid
);
  localparam int CMAX = CLK_DIV > SAMPLE_GAP ? CLK_DIV : SAMPLE_GAP;
  localparam int CW = $clog2(CMAX + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] half;
  logic [TEMP_W-1:0] shreg, avg_in, avg_out;
  temp_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_in (
    .clk(clk), .rst(rst), .in_valid(state == DONE && adc_ch == CH_INSIDE),
    .in_data(shreg), .avg(avg_in)
  );
  temp_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_out (
    .clk(clk), .rst(rst), .in_valid(state == DONE && adc_ch == CH_OUTSIDE),
    .in_data(shreg), .avg(avg_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      // GAP with an expired count so SETUP starts on the first edge after release
      state <= GAP;
      cnt <= '0;
      half <= '0;
      shreg <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      adc_ch <= CH_INSIDE;
      greenhouse_temp <= '0;
      outside_temp <= '0;
      temp_g_greenhouse_temp <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        GAP: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= SETUP;
            adc_cs_n <= 1'b0;
            cnt <= CW'(CLK_DIV - 1);
          end
        end
        SETUP: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= SHIFT;
            adc_sclk <= 1'b1;
            half <= '0;
            cnt <= CW'(CLK_DIV - 1);
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            cnt <= CW'(CLK_DIV - 1);
            half <= half + 1'b1;
            adc_sclk <= ~adc_sclk & (half != 4'd15);
            if (adc_sclk) shreg <= {shreg[TEMP_W-2:0], adc_sdo};
            if (half == 4'd15) begin
              state <= DONE;
              adc_cs_n <= 1'b1;
            end
          end
        end
        DONE: begin
          if (adc_ch == CH_INSIDE) begin
            adc_ch <= CH_OUTSIDE;
            state <= SETUP;
            adc_cs_n <= 1'b0;
            cnt <= CW'(CLK_DIV - 1);
          end else begin
            adc_ch <= CH_INSIDE;
            state <= GAP;
            cnt <= CW'(SAMPLE_GAP - 1);
            greenhouse_temp <= avg_in;
            outside_temp <= avg_out;
            temp_g_greenhouse_temp <= avg_out > avg_in;
            sample_valid <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_temp_sampler.sv
// tb_temp_sampler: directed checks of ADC framing, averaging, flag and reset behaviour
module tb_temp_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic adc_sdo, adc_cs_n, adc_sclk, adc_ch;
  logic [7:0] greenhouse_temp, outside_temp;
  logic temp_g_greenhouse_temp, sample_valid;
  logic [7:0] in_w = 8'h32, out_w = 8'h14, cur;
  logic [2:0] bidx = 3'd7;
  int checks = 0, errors = 0;

  temp_sampler dut (
    .clk(clk), .rst(rst), .adc_sdo(adc_sdo), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_ch(adc_ch), .greenhouse_temp(greenhouse_temp), .outside_temp(outside_temp),
    .temp_g_greenhouse_temp(temp_g_greenhouse_temp), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // ADC model: MSB presented at cs_n fall, next bit after each sclk fall
  assign cur = adc_ch ? out_w : in_w;
  assign adc_sdo = cur[bidx];
  always @(negedge adc_cs_n) bidx = 3'd7;
  always @(negedge adc_sclk) bidx = bidx - 3'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!sample_valid && n < 3000);
    check("valid_timeout", sample_valid, 1);
  endtask

  task automatic expect_pulse(input string tag, input int gt, input int ot, input int fl);
    int n;
    wait_valid(n);
    check({tag, "_gt"}, greenhouse_temp, gt);
    check({tag, "_ot"}, outside_temp, ot);
    check({tag, "_flag"}, temp_g_greenhouse_temp, fl);
  endtask

  task automatic release_and_prime(input string tag, input int gt, input int ot, input int fl);
    int n;
    rst = 1'b0;
    @(posedge clk); #1;
    check({tag, "_cs_fall"}, adc_cs_n, 0);
    wait_valid(n);
    check({tag, "_latency"}, n, 138);
    check({tag, "_gt"}, greenhouse_temp, gt);
    check({tag, "_ot"}, outside_temp, ot);
    check({tag, "_flag"}, temp_g_greenhouse_temp, fl);
  endtask

  // framing monitor: window lengths, sclk edges, channel stability, gaps, pulse period
  logic prev_cs = 1'b1, prev_sclk = 1'b0, win_ch = 1'b0, last_ch = 1'b0, ch_bad = 1'b0;
  logic fresh = 1'b1, have_prev = 1'b0;
  int len = 0, rises = 0, cyc = 0, prev_t = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      fresh = 1'b1; have_prev = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b0;
      len = 0; rises = 0; ch_bad = 1'b0;
    end else begin
      if (adc_cs_n !== prev_cs) begin
        if (!prev_cs) begin
          check("cs_low_len", len, 68);
          check("sclk_rises", rises, 8);
          check("ch_stable", ch_bad, 0);
          last_ch = win_ch;
        end else if (!fresh) begin
          check(last_ch ? "gap_pairs" : "gap_channels", len, last_ch ? 1001 : 1);
        end
        fresh = 1'b0; len = 0; rises = 0; ch_bad = 1'b0; win_ch = adc_ch;
      end
      len++;
      if (adc_sclk && !prev_sclk) rises++;
      if (!adc_cs_n && adc_ch !== win_ch) ch_bad = 1'b1;
      if (sample_valid) begin
        if (have_prev) check("valid_period", cyc - prev_t, 1138);
        have_prev = 1'b1;
        prev_t = cyc;
      end
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_ch", adc_ch, 0);
    check("rst_gt", greenhouse_temp, 0);
    check("rst_ot", outside_temp, 0);
    check("rst_flag", temp_g_greenhouse_temp, 0);
    check("rst_valid", sample_valid, 0);
    release_and_prime("prime", 50, 20, 0);
    in_w = 8'd60;
    expect_pulse("step1", 52, 20, 0);
    expect_pulse("step2", 55, 20, 0);
    expect_pulse("step3", 57, 20, 0);
    expect_pulse("step4", 60, 20, 0);
    // land in the ch1 high half-period of bit 3 and reset there
    n = 0;
    while (!(!adc_cs_n && adc_ch) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ch1_window_found", n < 3000, 1);
    repeat (30) @(posedge clk);
    #1;
    check("pre_rst_shifting", adc_cs_n == 0 && adc_sclk == 1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cs_n", adc_cs_n, 1);
    check("mid_rst_sclk", adc_sclk, 0);
    check("mid_rst_gt", greenhouse_temp, 0);
    check("mid_rst_ot", outside_temp, 0);
    check("mid_rst_flag", temp_g_greenhouse_temp, 0);
    check("mid_rst_valid", sample_valid, 0);
    in_w = 8'd40;
    out_w = 8'd40;
    release_and_prime("equal", 40, 40, 0);
    out_w = 8'd44;
    expect_pulse("warmer", 40, 41, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    in_w = 8'hA5;
    out_w = 8'hA5;
    release_and_prime("a5", 165, 165, 0);
    in_w = 8'hFF;
    out_w = 8'hFF;
    expect_pulse("ff1", 187, 187, 0);
    expect_pulse("ff2", 210, 210, 0);
    expect_pulse("ff3", 232, 232, 0);
    expect_pulse("ff4", 255, 255, 0);
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
